// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier controller.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_M,
    LOAD_Q,
    ARITH,
    SHIFT,
    OUT_A,
    OUT_Q,
    DONE
  } booth_state_t;

  localparam int C0_IDX = 0;
  localparam int C1_IDX = 1;
  localparam int C2_IDX = 2;
  localparam int C3_IDX = 3;
  localparam int C4_IDX = 4;
  localparam int C5_IDX = 5;
  localparam int C6_IDX = 6;
  localparam int C7_IDX = 7;

  localparam logic [1:0] DEC_ADD = 2'b01;
  localparam logic [1:0] DEC_SUB = 2'b10;

  // Registered strobe value for a state; c3/c4 depend on q0/q_1 and are decoded elsewhere.
  function automatic logic strobe_on(booth_state_t s, int idx);
    logic on;
    on = 1'b0;
    case (idx)
      C0_IDX:  on = (s == LOAD_Q);
      C1_IDX:  on = (s == LOAD_M);
      C2_IDX:  on = (s == LOAD_Q);
      C5_IDX:  on = (s == SHIFT);
      C6_IDX:  on = (s == OUT_A);
      C7_IDX:  on = (s == OUT_Q);
      default: on = 1'b0;
    endcase
    return on;
  endfunction

endpackage

// File: rtl/booth_iter_cnt.sv
// Booth iteration counter; last flags the final iteration so the FSM exits before any wrap.
module booth_iter_cnt
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [$clog2(N)-1:0] cnt,
  output logic                 last
);

  localparam int CW = $clog2(N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CW'(N - 1));

endmodule

// File: rtl/booth_ctrl.sv
// Radix-2 Booth multiplier control FSM; optional sticky protocol error output under BOOTH_CTRL_ERR_EN.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  input  logic q_1,
  output logic ready,
  output logic done,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c5,
  output logic c6,
  output logic c7
`ifdef BOOTH_CTRL_ERR_EN
  ,
  output logic err
`endif
);

  localparam int CW = $clog2(N);

  booth_state_t    state;
  booth_state_t    next_state;
  logic [CW-1:0]   cnt;
  logic            last;
  logic [1:0]      dec;

  booth_iter_cnt #(.N(N)) u_iter_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == LOAD_Q),
    .inc  ((state == SHIFT) && !last),
    .cnt  (cnt),
    .last (last)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD_M;
      LOAD_M:  next_state = LOAD_Q;
      LOAD_Q:  next_state = ARITH;
      ARITH:   next_state = SHIFT;
      SHIFT:   next_state = last ? OUT_A : ARITH;
      OUT_A:   next_state = OUT_Q;
      OUT_Q:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      c0    <= 1'b0;
      c1    <= 1'b0;
      c2    <= 1'b0;
      c5    <= 1'b0;
      c6    <= 1'b0;
      c7    <= 1'b0;
    end else begin
      state <= next_state;
      ready <= (next_state == IDLE);
      done  <= (next_state == DONE);
      c0    <= strobe_on(next_state, C0_IDX);
      c1    <= strobe_on(next_state, C1_IDX);
      c2    <= strobe_on(next_state, C2_IDX);
      c5    <= strobe_on(next_state, C5_IDX);
      c6    <= strobe_on(next_state, C6_IDX);
      c7    <= strobe_on(next_state, C7_IDX);
    end
  end

  assign dec = {q0, q_1};
  assign c3  = (state == ARITH) && ((dec == DEC_ADD) || (dec == DEC_SUB));
  assign c4  = (state == ARITH) && (dec == DEC_SUB);

`ifdef BOOTH_CTRL_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (start && (state != IDLE) && (state != DONE)) begin
      err <= 1'b1;
    end
  end
`endif

  // The counter holds at N-1 on exit, so the readout always follows exactly N iterations.
  a_full_iterations: assert property (@(posedge clk) disable iff (rst)
    (state == OUT_A) |-> (cnt == CW'(N - 1)));

endmodule

// File: tb/tb_booth_ctrl.sv
// Directed bench for booth_ctrl with a behavioural Booth datapath model (N=8).
module tb_booth_ctrl;

  logic clk;
  logic rst;
  logic start;
  logic q0;
  logic q_1;
  logic ready;
  logic done;
  logic c0, c1, c2, c3, c4, c5, c6, c7;
`ifdef BOOTH_CTRL_ERR_EN
  logic err;
`endif

  int checks = 0;
  int errors = 0;

  logic       use_model = 1'b0;
  logic       q0_drv = 1'b0;
  logic       q1_drv = 1'b0;
  logic [7:0] m_in = 8'h00;
  logic [7:0] q_in = 8'h00;
  logic [7:0] dp_a = 8'h00;
  logic [7:0] dp_q = 8'h00;
  logic [7:0] dp_m = 8'h00;
  logic       dp_q1 = 1'b0;
  logic [7:0] obus;

  int c1_at, c02_at, c5_cnt, c3_cnt, c6_at, c7_at, done_at, done_cnt, ready_at, overlap;
  logic [7:0] obus_a, obus_q;

  booth_ctrl #(.N(8)) dut (
`ifdef BOOTH_CTRL_ERR_EN
    .err   (err),
`endif
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .q0    (q0),
    .q_1   (q_1),
    .ready (ready),
    .done  (done),
    .c0    (c0),
    .c1    (c1),
    .c2    (c2),
    .c3    (c3),
    .c4    (c4),
    .c5    (c5),
    .c6    (c6),
    .c7    (c7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign q0   = use_model ? dp_q[0] : q0_drv;
  assign q_1  = use_model ? dp_q1 : q1_drv;
  assign obus = c6 ? dp_a : (c7 ? dp_q : 8'h00);

  // Booth datapath driven by the controller strobes.
  always @(posedge clk) begin
    if (c0) begin
      dp_a  <= 8'h00;
      dp_q1 <= 1'b0;
    end
    if (c1) dp_m <= m_in;
    if (c2) dp_q <= q_in;
    if (c3) dp_a <= c4 ? dp_a - dp_m : dp_a + dp_m;
    if (c5) {dp_a, dp_q, dp_q1} <= {dp_a[7], dp_a, dp_q};
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Pulses start at a negedge, then traces 30 cycles; cycle 1 is the one after the accepting edge.
  task automatic applyStimulus(input logic [7:0] m, input logic [7:0] q, input logic model);
    m_in      = m;
    q_in      = q;
    use_model = model;
    q0_drv    = 1'b0;
    q1_drv    = 1'b0;
    c1_at = -1; c02_at = -1; c6_at = -1; c7_at = -1; done_at = -1; ready_at = -1;
    c5_cnt = 0; c3_cnt = 0; done_cnt = 0; overlap = 0;
    obus_a = 8'h00; obus_q = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (c1 && c1_at < 0) c1_at = cyc;
      if (c0 && c2 && c02_at < 0) c02_at = cyc;
      if (c5) c5_cnt++;
      if (c3) c3_cnt++;
      if (c6 && c7) overlap++;
      if (c6 && c6_at < 0) begin c6_at = cyc; obus_a = obus; end
      if (c7 && c7_at < 0) begin c7_at = cyc; obus_q = obus; end
      if (done) begin done_cnt++; if (done_at < 0) done_at = cyc; end
      if (ready && ready_at < 0) ready_at = cyc;
      @(negedge clk);
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_idle", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int c1n, dn;
    rst   = 1'b1;
    start = 1'b0;
    #3;
    checkOutput("rst_ready", {31'd0, ready}, 32'd1);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_strobes", {24'd0, c7, c6, c5, c4, c3, c2, c1, c0}, 32'd0);
`ifdef BOOTH_CTRL_ERR_EN
    checkOutput("rst_err", {31'd0, err}, 32'd0);
`endif
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_hold", {22'd0, ready, done, c7, c6, c5, c4, c3, c2, c1, c0}, 32'h200);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] idle decode trace");
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("idle_c1_at", c1_at, 1);
    checkOutput("idle_c0c2_at", c02_at, 2);
    checkOutput("idle_c5_cnt", c5_cnt, 8);
    checkOutput("idle_c3_cnt", c3_cnt, 0);
    checkOutput("idle_c6_at", c6_at, 19);
    checkOutput("idle_c7_at", c7_at, 20);
    checkOutput("idle_done_at", done_at, 21);
    checkOutput("idle_done_cnt", done_cnt, 1);
    checkOutput("idle_ready_at", ready_at, 22);
    checkOutput("idle_c6c7_overlap", overlap, 0);

    $display("[TB] ARITH decode");
    use_model = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("dec_00", {30'd0, c3, c4}, 32'd0);
    {q0_drv, q1_drv} = 2'b10; #1;
    checkOutput("dec_10", {30'd0, c3, c4}, 32'd3);
    {q0_drv, q1_drv} = 2'b01; #1;
    checkOutput("dec_01", {30'd0, c3, c4}, 32'd2);
    {q0_drv, q1_drv} = 2'b11; #1;
    checkOutput("dec_11", {30'd0, c3, c4}, 32'd0);
    {q0_drv, q1_drv} = 2'b10;
    @(negedge clk);
    checkOutput("dec_shift_c5", {31'd0, c5}, 32'd1);
    checkOutput("dec_shift_no_c3", {30'd0, c3, c4}, 32'd0);
    {q0_drv, q1_drv} = 2'b00;
    waitIdle();

    $display("[TB] full multiplies");
    applyStimulus(8'hFB, 8'h03, 1'b1);
    checkOutput("mul_m5x3_a", obus_a, 32'hFF);
    checkOutput("mul_m5x3_q", obus_q, 32'hF1);
    checkOutput("mul_m5x3_done_at", done_at, 21);
    applyStimulus(8'h07, 8'h03, 1'b1);
    checkOutput("mul_7x3_a", obus_a, 32'h00);
    checkOutput("mul_7x3_q", obus_q, 32'h15);
    checkOutput("mul_7x3_c6c7_overlap", overlap, 0);

    $display("[TB] start held high");
    use_model = 1'b0;
    c1n = 0;
    dn  = 0;
    start = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (cyc == 39) start = 1'b0;
      if (c1) c1n++;
      if (done) dn++;
    end
    checkOutput("held_accepts", c1n, 2);
    checkOutput("held_dones", dn, 2);
`ifdef BOOTH_CTRL_ERR_EN
    checkOutput("err_sticky", {31'd0, err}, 32'd1);
    rst = 1'b1; #1;
    checkOutput("err_cleared", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    $display("[TB] reset mid-operation");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("midop_in_shift", {31'd0, c5}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midop_rst_outputs", {22'd0, ready, done, c7, c6, c5, c4, c3, c2, c1, c0}, 32'h200);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge clk);
      if (done) dn++;
    end
    checkOutput("midop_no_done", dn, 0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("restart_c5_cnt", c5_cnt, 8);
    checkOutput("restart_done_at", done_at, 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
